cursor_key_decoder: RTL and testbench

- Consumer side of the keypad cursor interface. Takes the 3x4 grid cursor position (x 0..2, y 0..3) and an active-low select button.
- On each select press, decodes the cell under the cursor into a calculator key code. Held digit keys auto-repeat.
- Key codes pass through a small first-word-fall-through FIFO to the calculator core, using a valid/ready handshake.

---
 rtl/cursor_key_decoder.sv | 166 ++++++++++++++++
 tb/tb_cursor_key_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_key_decoder.sv
// Cursor key decoder: turns select presses on the 3x4 keypad grid into
// calculator key codes, auto-repeats held digit keys, and queues the codes
// in a first-word-fall-through FIFO with a valid/ready handshake.
module cursor_key_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int CNT_W      = 26
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    cursor_x,
  input  logic [3:0]                    cursor_y,
  input  logic                          btn_sel,
  input  logic                          key_ready,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic                          key_is_digit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  // Returns {cell_valid, is_digit, code[3:0]} for a grid position.
  function automatic logic [5:0] decode_cell(input logic [3:0] x, input logic [3:0] y);
    logic [5:0] r;
    r = 6'b0;
    if (x <= 4'd2 && y <= 4'd3) begin
      if (y == 4'd3) begin
        case (x)
          4'd0:    r = 6'b10_1010;   // CLR
          4'd1:    r = 6'b11_0000;   // digit 0
          default: r = 6'b10_1011;   // ENT
        endcase
      end else begin
        r = {2'b11, 4'(y * 4'd3 + x + 4'd1)};
      end
    end
    return r;
  endfunction

  logic             btn_sel_d;
  logic             press_pulse;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       lat_q, lat_d;     // {is_digit, code} latched at press
  logic [5:0]       dec;
  logic             push;
  logic [4:0]       push_ent;

  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [4:0]       last_ent;
  logic [4:0]       head;
  logic             pop, full, wr_en;

  assign dec         = decode_cell(cursor_x, cursor_y);
  assign press_pulse = ~btn_sel & btn_sel_d;

  // Button history, state, hold counter and latched key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sel_d <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
    end else begin
      btn_sel_d <= btn_sel;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
    end
  end

  // Next-state logic: press latching, hold timing and repeat pushes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    push     = 1'b0;
    push_ent = lat_q;
    case (state_q)
      IDLE: begin
        if (press_pulse) begin
          lat_d    = dec[4:0];
          push_ent = dec[4:0];
          push     = dec[5];
          cnt_d    = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (btn_sel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Invalid cells latch is_digit=0, so they never repeat either.
          if (REPEAT_DLY != 0 && lat_q[4] && cnt_q == DLY_LAST) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end
        end
      end
      REPEAT: begin
        if (btn_sel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PER_LAST) begin
            push  = 1'b1;
            cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_valid  = (count != '0);
  assign full       = (count == FULL_CNT);
  assign pop        = key_valid & key_ready;
  assign wr_en      = push & (~full | pop);
  assign fifo_count = count;

  // When empty the outputs hold the most recently popped entry.
  assign head         = key_valid ? mem[rd_ptr] : last_ent;
  assign key_code     = head[3:0];
  assign key_is_digit = head[4];

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_ent;
  end

  // FIFO pointers, occupancy, last popped entry and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_ent <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_ent <= mem[rd_ptr];
      end
      if (push && full && !pop) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_key_decoder.sv
// Bench for cursor_key_decoder: a time-based behavioural model plus a queue
// FIFO is compared with the DUT every cycle, and directed scenarios pin
// specific hand-computed results.
module tb_cursor_key_decoder;

  localparam int D   = 4;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic       clk, rst_n;
  logic [3:0] cursor_x, cursor_y;
  logic       btn_sel, key_ready;
  logic       key_valid, key_is_digit, overflow;
  logic [3:0] key_code;
  logic [$clog2(D):0] fifo_count;

  int total = 0;
  int bad   = 0;

  cursor_key_decoder #(.FIFO_DEPTH(D), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .CNT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .btn_sel(btn_sel), .key_ready(key_ready), .key_valid(key_valid),
    .key_code(key_code), .key_is_digit(key_is_digit), .fifo_count(fifo_count),
    .overflow(overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         ktab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  logic [4:0] mq [$];
  logic [4:0] m_last;
  logic [4:0] m_lat;
  bit         m_ovf, m_held, m_prev;
  int         m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = '0; m_lat = '0; m_ovf = 0; m_held = 0; m_prev = 1; m_n = 0;
    end else begin
      bit push, pop_ok;
      int code;
      push = 0;
      if (!m_held) begin
        if (!btn_sel && m_prev) begin
          m_held = 1;
          m_n    = 0;
          if (cursor_x < 3 && cursor_y < 4) begin
            code  = ktab[int'(cursor_y) * 3 + int'(cursor_x)];
            m_lat = {(code < 10) ? 1'b1 : 1'b0, 4'(code)};
            push  = 1;
          end else begin
            m_lat = '0;
          end
        end
      end else if (btn_sel) begin
        m_held = 0;
      end else begin
        m_n++;
        if (m_lat[4] && m_n >= DLY && ((m_n - DLY) % PER) == 0) push = 1;
      end
      pop_ok = (mq.size() != 0) && key_ready;
      if (pop_ok) m_last = mq.pop_front();
      if (push) begin
        if (mq.size() < D) mq.push_back(m_lat);
        else m_ovf = 1;
      end
      m_prev = btn_sel;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [4:0] eh;
    eh = (mq.size() != 0) ? mq[0] : m_last;
    check("key_valid",    key_valid,    (mq.size() != 0) ? 1 : 0);
    check("fifo_count",   fifo_count,   mq.size());
    check("key_code",     key_code,     eh[3:0]);
    check("key_is_digit", key_is_digit, eh[4]);
    check("overflow",     overflow,     m_ovf);
  end

  // Record accepted codes and cycles with key_valid high.
  int drained [$];
  int vcnt;
  always @(negedge clk) begin
    if (key_valid && key_ready) drained.push_back(int'(key_code));
    if (key_valid) vcnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cyc();
    rst_n = 1'b1;
    cyc();
    drained.delete();
    vcnt = 0;
  endtask

  task automatic press(input int x, input int y, input int n);
    cursor_x = 4'(x);
    cursor_y = 4'(y);
    btn_sel  = 1'b0;
    repeat (n) cyc();
    btn_sel  = 1'b1;
  endtask

  function automatic int at(input int i);
    return (i < drained.size()) ? drained[i] : -1;
  endfunction

  initial begin
    rst_n = 1'b0; btn_sel = 1'b1; key_ready = 1'b0;
    cursor_x = '0; cursor_y = '0; vcnt = 0;
    #2;
    check("rst_valid", key_valid, 0);
    check("rst_code",  key_code, 0);
    check("rst_digit", key_is_digit, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf",   overflow, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    drained.delete(); vcnt = 0;

    // Short press on 5, no repeat.
    key_ready = 1'b1;
    press(1, 1, 3);
    repeat (20) cyc();
    check("t1_entries", drained.size(), 1);
    check("t1_code", at(0), 5);
    check("t1_valid_cycles", vcnt, 1);

    // Long hold on CLR never repeats.
    do_reset();
    key_ready = 1'b1;
    press(0, 3, 30);
    repeat (10) cyc();
    check("t2_entries", drained.size(), 1);
    check("t2_code", at(0), 10);

    // Hold 9 for 20 cycles, moving the cursor mid-hold.
    do_reset();
    key_ready = 1'b1;
    cursor_x = 4'd2; cursor_y = 4'd2; btn_sel = 1'b0;
    repeat (10) cyc();
    cursor_x = 4'd0; cursor_y = 4'd0;
    repeat (10) cyc();
    btn_sel = 1'b1;
    repeat (20) cyc();
    check("t3_entries", drained.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_code", at(i), 9);

    // Fill with 0s, fifth press overflows.
    do_reset();
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin press(1, 3, 2); repeat (2) cyc(); end
    press(2, 3, 2);
    cyc();
    check("t4_count", fifo_count, 4);
    check("t4_ovf", overflow, 1);
    key_ready = 1'b1;
    repeat (8) cyc();
    check("t4_entries", drained.size(), 4);
    for (int i = 0; i < 4; i++) check("t4_code", at(i), 0);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin press(1, 3, 2); repeat (2) cyc(); end
    cursor_x = 4'd2; cursor_y = 4'd3; btn_sel = 1'b0; key_ready = 1'b1;
    cyc();
    check("t5_count", fifo_count, 4);
    check("t5_ovf", overflow, 0);
    btn_sel = 1'b1;
    repeat (8) cyc();
    check("t5_entries", drained.size(), 5);
    check("t5_last", at(4), 11);
    check("t5_ovf_end", overflow, 0);

    // Invalid cell, then reset during repeat.
    do_reset();
    key_ready = 1'b1;
    press(3, 0, 2);
    repeat (4) cyc();
    check("t6_valid", key_valid, 0);
    check("t6_count", fifo_count, 0);
    check("t6_vcyc", vcnt, 0);
    key_ready = 1'b0;
    cursor_x = 4'd0; cursor_y = 4'd0; btn_sel = 1'b0;
    repeat (11) cyc();
    check("t6_rep_count", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_code",  key_code, 0);
    check("t6_rst_digit", key_is_digit, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_ovf",   overflow, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_post_rst_press", fifo_count, 1);
    check("t6_post_rst_code", key_code, 1);
    btn_sel = 1'b1;
    repeat (5) cyc();
    check("t6_no_repeat", fifo_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
